// File: rtl/truth_table_sweep.sv
// ============================================================================
// Module   : truth_table_sweep
// Brief    : Sweeps all 2^NUM_IN input vectors into a 7-input function and
//            returns its truth table and onset weight over valid/ready.
//            Define TTS_SELFDUAL_EN to add the registered self-duality flag.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module truth_table_sweep #(
    parameter int NUM_IN = 7,
    parameter int SETTLE = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    output logic         busy,
    output logic         x0,
    output logic         x1,
    output logic         x2,
    output logic         x3,
    output logic         x4,
    output logic         x5,
    output logic         x6,
    input  logic         f,
    output logic [127:0] tt,
    output logic [7:0]   weight,
    output logic         self_dual,
    output logic         tt_valid,
    input  logic         tt_ready
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        SAMPLE = 2'd2,
        HOLD   = 2'd3
    } state_t;

    localparam logic [6:0] LAST_V      = 7'((1 << NUM_IN) - 1);
    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);
    // With no settle time each vector is sampled in the cycle it is presented.
    localparam state_t     FIRST_ST    = (SETTLE == 0) ? SAMPLE : DRIVE;

    state_t       r_state, w_state;
    logic [6:0]   r_v, w_v;
    logic [3:0]   r_settle, w_settle;
    logic [127:0] r_tt, w_tt;
    logic [7:0]   r_weight, w_weight;
    logic         r_busy, w_busy;
    logic         r_valid, w_valid;

`ifdef TTS_SELFDUAL_EN
    localparam int TT_LEN = 1 << NUM_IN;
    logic r_sd, w_sd;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_v      <= 7'd0;
            r_settle <= 4'd0;
            r_tt     <= 128'd0;
            r_weight <= 8'd0;
            r_busy   <= 1'b0;
            r_valid  <= 1'b0;
`ifdef TTS_SELFDUAL_EN
            r_sd     <= 1'b0;
`endif
        end else begin
            r_state  <= w_state;
            r_v      <= w_v;
            r_settle <= w_settle;
            r_tt     <= w_tt;
            r_weight <= w_weight;
            r_busy   <= w_busy;
            r_valid  <= w_valid;
`ifdef TTS_SELFDUAL_EN
            r_sd     <= w_sd;
`endif
        end
    end

    always_comb begin
        w_state  = r_state;
        w_v      = r_v;
        w_settle = r_settle;
        w_tt     = r_tt;
        w_weight = r_weight;
        w_busy   = r_busy;
        w_valid  = r_valid;
`ifdef TTS_SELFDUAL_EN
        w_sd     = r_sd;
`endif
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state  = FIRST_ST;
                    w_v      = 7'd0;
                    w_settle = 4'd0;
                    w_tt     = 128'd0;
                    w_weight = 8'd0;
                    w_busy   = 1'b1;
`ifdef TTS_SELFDUAL_EN
                    w_sd     = 1'b0;
`endif
                end
            end
            DRIVE: begin
                if (r_settle == SETTLE_LAST) begin
                    w_state = SAMPLE;
                end else begin
                    w_settle = r_settle + 4'd1;
                end
            end
            SAMPLE: begin
                w_tt[r_v] = f;
                w_weight  = r_weight + {7'd0, f};
                if (r_v == LAST_V) begin
                    // x outputs return to 0 by clearing the vector counter.
                    w_state = HOLD;
                    w_v     = 7'd0;
                    w_valid = 1'b1;
`ifdef TTS_SELFDUAL_EN
                    w_sd = 1'b1;
                    for (int i = 0; i < TT_LEN; i++) begin
                        if (w_tt[i] == w_tt[TT_LEN - 1 - i]) begin
                            w_sd = 1'b0;
                        end
                    end
`endif
                end else begin
                    w_state  = FIRST_ST;
                    w_v      = r_v + 7'd1;
                    w_settle = 4'd0;
                end
            end
            HOLD: begin
                if (tt_ready) begin
                    w_state = IDLE;
                    w_valid = 1'b0;
                    w_busy  = 1'b0;
                end
            end
            default: begin
                w_state = IDLE;
            end
        endcase
    end

    assign {x6, x5, x4, x3, x2, x1, x0} = r_v;
    assign tt       = r_tt;
    assign weight   = r_weight;
    assign busy     = r_busy;
    assign tt_valid = r_valid;

`ifdef TTS_SELFDUAL_EN
    assign self_dual = r_sd;
`else
    assign self_dual = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_truth_table_sweep.sv
// Bench for truth_table_sweep: a 7-input/SETTLE=1 instance and a 3-input/SETTLE=0 instance.
`timescale 1ns/1ps
`default_nettype none

module tb_truth_table_sweep;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic         start7 = 1'b0, start3 = 1'b0, rdy7 = 1'b0, rdy3 = 1'b0;
    logic         busy7, busy3, val7, val3, sd7, sd3, f7, f3;
    logic [127:0] tt7, tt3;
    logic [7:0]   w7, w3;
    logic [6:0]   xv7, xv3;
    int           fsel = 0;
    bit           use3 = 1'b0;
    int           n_chk = 0, n_fail = 0;

`ifdef TTS_SELFDUAL_EN
    localparam bit SD_ON = 1'b1;
`else
    localparam bit SD_ON = 1'b0;
`endif

    // Functions under classification: 0 zero, 1 x6, 2 x0, 3 x0&x1, 4 maj(x0,x1,x2), 5 one
    function automatic logic fn(input int s, input logic [6:0] v);
        case (s)
            1:       return v[6];
            2:       return v[0];
            3:       return v[0] & v[1];
            4:       return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
            5:       return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    always_comb f7 = fn(fsel, xv7);
    always_comb f3 = fn(fsel, xv3);

    truth_table_sweep #(.NUM_IN(7), .SETTLE(1)) dut7 (
        .clk(clk), .rst(rst), .start(start7), .busy(busy7),
        .x0(xv7[0]), .x1(xv7[1]), .x2(xv7[2]), .x3(xv7[3]),
        .x4(xv7[4]), .x5(xv7[5]), .x6(xv7[6]),
        .f(f7), .tt(tt7), .weight(w7), .self_dual(sd7),
        .tt_valid(val7), .tt_ready(rdy7)
    );

    truth_table_sweep #(.NUM_IN(3), .SETTLE(0)) dut3 (
        .clk(clk), .rst(rst), .start(start3), .busy(busy3),
        .x0(xv3[0]), .x1(xv3[1]), .x2(xv3[2]), .x3(xv3[3]),
        .x4(xv3[4]), .x5(xv3[5]), .x6(xv3[6]),
        .f(f3), .tt(tt3), .weight(w3), .self_dual(sd3),
        .tt_valid(val3), .tt_ready(rdy3)
    );

    logic [127:0] c_tt;
    logic [7:0]   c_w;
    logic [6:0]   c_x;
    logic         c_sd, c_val, c_busy;
    always_comb begin
        c_tt   = use3 ? tt3   : tt7;
        c_w    = use3 ? w3    : w7;
        c_x    = use3 ? xv3   : xv7;
        c_sd   = use3 ? sd3   : sd7;
        c_val  = use3 ? val3  : val7;
        c_busy = use3 ? busy3 : busy7;
    end

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    typedef struct {
        bit           use3;
        int           fsel;
        logic [127:0] tt;
        logic [7:0]   w;
        logic         sd;
        int           lat;
    } vec_t;

    vec_t vecs[7];

    task automatic do_start();
        @(posedge clk); #1;
        if (use3) start3 = 1'b1; else start7 = 1'b1;
        @(posedge clk); #1;
        start3 = 1'b0;
        start7 = 1'b0;
    endtask

    task automatic do_ack();
        if (use3) rdy3 = 1'b1; else rdy7 = 1'b1;
        @(posedge clk); #1;
        rdy3 = 1'b0;
        rdy7 = 1'b0;
        chk("ack_valid_drop", {127'd0, c_val}, 128'd0);
        chk("ack_busy_drop", {127'd0, c_busy}, 128'd0);
    endtask

    // Runs one table entry up to HOLD; acknowledges only if ack is set.
    task automatic run_vec(input int k, input bit ack);
        int n;
        bit hi_bad;
        use3 = vecs[k].use3;
        fsel = vecs[k].fsel;
        do_start();
        chk($sformatf("v%0d_first_x", k), {121'd0, c_x}, 128'd0);
        chk($sformatf("v%0d_busy", k), {127'd0, c_busy}, 128'd1);
        n = 0;
        hi_bad = 1'b0;
        while (!c_val && n < 600) begin
            @(posedge clk); #1;
            n++;
            if (use3 && xv3[6:3] != 4'd0) hi_bad = 1'b1;
        end
        chk($sformatf("v%0d_latency", k), 128'(n), 128'(vecs[k].lat));
        chk($sformatf("v%0d_tt", k), c_tt, vecs[k].tt);
        chk($sformatf("v%0d_weight", k), {120'd0, c_w}, {120'd0, vecs[k].w});
        chk($sformatf("v%0d_self_dual", k), {127'd0, c_sd}, {127'd0, vecs[k].sd & SD_ON});
        chk($sformatf("v%0d_hold_x", k), {121'd0, c_x}, 128'd0);
        if (use3) chk($sformatf("v%0d_x_high_zero", k), {127'd0, hi_bad}, 128'd0);
        if (ack) do_ack();
    endtask

    initial begin
        int n;
        int bad;
        logic [127:0] saved;

        vecs[0] = '{1'b0, 0, 128'd0, 8'd0, 1'b0, 256};
        vecs[1] = '{1'b0, 1, {{64{1'b1}}, 64'd0}, 8'd64, 1'b1, 256};
        vecs[2] = '{1'b0, 2, {32{4'hA}}, 8'd64, 1'b1, 256};
        vecs[3] = '{1'b1, 3, 128'h88, 8'd2, 1'b0, 8};
        vecs[4] = '{1'b1, 4, 128'hE8, 8'd4, 1'b1, 8};
        vecs[5] = '{1'b1, 5, 128'hFF, 8'd8, 1'b0, 8};
        vecs[6] = '{1'b0, 5, {128{1'b1}}, 8'd128, 1'b0, 256};

        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs7", {tt7, w7, xv7, sd7, val7, busy7}, '0);
        chk("reset_outputs3", {tt3, w3, xv3, sd3, val3, busy3}, '0);
        rst = 1'b0;

        for (int k = 0; k < 7; k++) run_vec(k, 1'b1);

        // Backpressure with a start pulse while holding the result.
        run_vec(1, 1'b0);
        saved = tt7;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            start7 = (i == 5);
            @(posedge clk); #1;
            if (!val7 || !busy7 || tt7 !== saved || xv7 != 7'd0) bad++;
        end
        start7 = 1'b0;
        chk("bp_stable_cycles_bad", 128'(bad), 128'd0);
        do_ack();

        // Asynchronous reset in the middle of a sweep.
        use3 = 1'b0;
        fsel = 2;
        do_start();
        n = 0;
        while (xv7 != 7'd40 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        chk("midsweep_reached_v40", {121'd0, xv7}, 128'd40);
        #2 rst = 1'b1;
        #1;
        chk("midsweep_reset_outputs", {tt7, w7, xv7, sd7, val7, busy7}, '0);
        @(posedge clk); #1;
        rst = 1'b0;
        run_vec(2, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
